// File: rtl/instruction_dispatch.sv
// instruction_dispatch: in-order FIFO that tags decoded instructions and hands each to one functional unit.
// Optional DISPATCH_PERF_EN builds the dispatch and stall-cycle counters.
module instruction_dispatch #(
    parameter int FIFO_DEPTH       = 4,
    parameter int NUM_FU           = 4,
    parameter int SEQ_WIDTH        = 6,
    parameter int immWidth         = 24,
    parameter int regWidth         = 5,
    parameter int opcodeWidth      = 6,
    parameter int XxoOpcodeWidth   = 10,
    parameter int formatIndexRange = 5,
    localparam int CW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clock_i,
    input  logic                        resetn_i,
    input  logic                        enable_i,
    input  logic [63:0]                 instructionAddress_i,
    input  logic [opcodeWidth-1:0]      opcode_i,
    input  logic [XxoOpcodeWidth-1:0]   xOpcode_i,
    input  logic                        xOpcodeEnable_i,
    input  logic [formatIndexRange-1:0] instructionFormat_i,
    input  logic [2:0]                  functionalUnitCode_i,
    input  logic [regWidth-1:0]         reg1_i,
    input  logic [regWidth-1:0]         reg2_i,
    input  logic [regWidth-1:0]         reg3_i,
    input  logic [1:0]                  reg1Use_i,
    input  logic [1:0]                  reg2Use_i,
    input  logic [1:0]                  reg3Use_i,
    input  logic                        reg1Enable_i,
    input  logic                        reg2Enable_i,
    input  logic                        reg3Enable_i,
    input  logic                        reg2ValOrZero_i,
    input  logic                        reg3IsImmediate_i,
    input  logic [immWidth-1:0]         imm_i,
    input  logic                        immEnable_i,
    input  logic                        bit1_i,
    input  logic                        bit2_i,
    input  logic [NUM_FU-1:0]           fuReady_i,
    output logic                        stall_o,
    output logic [NUM_FU-1:0]           fuValid_o,
    output logic [63:0]                 instructionAddress_o,
    output logic [opcodeWidth-1:0]      opcode_o,
    output logic [XxoOpcodeWidth-1:0]   xOpcode_o,
    output logic                        xOpcodeEnable_o,
    output logic [formatIndexRange-1:0] instructionFormat_o,
    output logic [2:0]                  functionalUnitCode_o,
    output logic [regWidth-1:0]         reg1_o,
    output logic [regWidth-1:0]         reg2_o,
    output logic [regWidth-1:0]         reg3_o,
    output logic [1:0]                  reg1Use_o,
    output logic [1:0]                  reg2Use_o,
    output logic [1:0]                  reg3Use_o,
    output logic                        reg1Enable_o,
    output logic                        reg2Enable_o,
    output logic                        reg3Enable_o,
    output logic                        reg2ValOrZero_o,
    output logic                        reg3IsImmediate_o,
    output logic [immWidth-1:0]         imm_o,
    output logic                        immEnable_o,
    output logic                        bit1_o,
    output logic                        bit2_o,
    output logic [SEQ_WIDTH-1:0]        seqTag_o,
    output logic [CW-1:0]               count_o,
    output logic                        badFu_o,
    output logic                        overflow_o,
    output logic [31:0]                 dispatchCount_o,
    output logic [31:0]                 stallCycles_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 64 + opcodeWidth + XxoOpcodeWidth + 1 + formatIndexRange + 3
                      + 3 * regWidth + 6 + 3 + 2 + immWidth + 3 + SEQ_WIDTH;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [3:0] NFU = 4'(NUM_FU);

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [EW-1:0]        wr_data, head;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [SEQ_WIDTH-1:0] seq;
    logic                 empty, full, push, pop, fire, code_ok, discard;

    assign wr_data = {instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i, instructionFormat_i,
                      functionalUnitCode_i, reg1_i, reg2_i, reg3_i, reg1Use_i, reg2Use_i, reg3Use_i,
                      reg1Enable_i, reg2Enable_i, reg3Enable_i, reg2ValOrZero_i, reg3IsImmediate_i,
                      imm_i, immEnable_i, bit1_i, bit2_i, seq};

    // An empty FIFO presents an all-zero head so payloads read 0 without resetting storage.
    assign head = empty ? '0 : mem[rd_ptr];
    assign {instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o, instructionFormat_o,
            functionalUnitCode_o, reg1_o, reg2_o, reg3_o, reg1Use_o, reg2Use_o, reg3Use_o,
            reg1Enable_o, reg2Enable_o, reg3Enable_o, reg2ValOrZero_o, reg3IsImmediate_o,
            imm_o, immEnable_o, bit1_o, bit2_o, seqTag_o} = head;

    assign empty     = count_o == '0;
    assign full      = count_o == DEPTH;
    assign stall_o   = count_o >= DEPTH - CW'(1);
    assign code_ok   = {1'b0, functionalUnitCode_o} < NFU;
    assign fuValid_o = (!empty && code_ok) ? NUM_FU'(1) << functionalUnitCode_o : '0;
    assign fire      = |(fuValid_o & fuReady_i);
    assign discard   = !empty && !code_ok;
    assign pop       = fire || discard;
    assign push      = enable_i && !full;

    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            seq        <= '0;
            overflow_o <= 1'b0;
            badFu_o    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + SEQ_WIDTH'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count_o <= count_o + CW'(push) - CW'(pop);
            if (enable_i && full) overflow_o <= 1'b1;
            badFu_o <= discard;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] dispatch_cnt, stall_cnt;
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            dispatch_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            dispatch_cnt <= dispatch_cnt + 32'(fire);
            stall_cnt    <= stall_cnt + 32'(stall_o);
        end
    end
    assign dispatchCount_o = dispatch_cnt;
    assign stallCycles_o   = stall_cnt;
`else
    assign dispatchCount_o = '0;
    assign stallCycles_o   = '0;
`endif
endmodule

// File: tb/tb_instruction_dispatch.sv
// tb_instruction_dispatch: table-driven vectors plus a dispatch scoreboard for instruction_dispatch.
module tb_instruction_dispatch;
    logic clock = 1'b0, resetn = 1'b0;
    always #5 clock = ~clock;

    logic        enable;
    logic [63:0] addr;
    logic [5:0]  opcode;
    logic [9:0]  xop;
    logic        xope;
    logic [4:0]  fmt;
    logic [2:0]  code;
    logic [4:0]  r1, r2, r3;
    logic [1:0]  u1, u2, u3;
    logic        e1, e2, e3, r2z, r3i;
    logic [23:0] imm;
    logic        imme, b1, b2;
    logic [3:0]  ready;

    logic        d_stall, d_xope, d_e1, d_e2, d_e3, d_r2z, d_r3i, d_imme, d_b1, d_b2, d_bad, d_ovf;
    logic [3:0]  d_fv;
    logic [63:0] d_addr;
    logic [5:0]  d_opcode, d_seq;
    logic [9:0]  d_xop;
    logic [4:0]  d_fmt, d_r1, d_r2, d_r3;
    logic [2:0]  d_code, d_count;
    logic [1:0]  d_u1, d_u2, d_u3;
    logic [23:0] d_imm;
    logic [31:0] d_dcnt, d_scnt;

    instruction_dispatch dut (
        .clock_i(clock), .resetn_i(resetn), .enable_i(enable),
        .instructionAddress_i(addr), .opcode_i(opcode), .xOpcode_i(xop), .xOpcodeEnable_i(xope),
        .instructionFormat_i(fmt), .functionalUnitCode_i(code),
        .reg1_i(r1), .reg2_i(r2), .reg3_i(r3), .reg1Use_i(u1), .reg2Use_i(u2), .reg3Use_i(u3),
        .reg1Enable_i(e1), .reg2Enable_i(e2), .reg3Enable_i(e3),
        .reg2ValOrZero_i(r2z), .reg3IsImmediate_i(r3i), .imm_i(imm), .immEnable_i(imme),
        .bit1_i(b1), .bit2_i(b2), .fuReady_i(ready),
        .stall_o(d_stall), .fuValid_o(d_fv),
        .instructionAddress_o(d_addr), .opcode_o(d_opcode), .xOpcode_o(d_xop), .xOpcodeEnable_o(d_xope),
        .instructionFormat_o(d_fmt), .functionalUnitCode_o(d_code),
        .reg1_o(d_r1), .reg2_o(d_r2), .reg3_o(d_r3), .reg1Use_o(d_u1), .reg2Use_o(d_u2), .reg3Use_o(d_u3),
        .reg1Enable_o(d_e1), .reg2Enable_o(d_e2), .reg3Enable_o(d_e3),
        .reg2ValOrZero_o(d_r2z), .reg3IsImmediate_o(d_r3i), .imm_o(d_imm), .immEnable_o(d_imme),
        .bit1_o(d_b1), .bit2_o(d_b2), .seqTag_o(d_seq), .count_o(d_count), .badFu_o(d_bad),
        .overflow_o(d_ovf), .dispatchCount_o(d_dcnt), .stallCycles_o(d_scnt)
    );

    typedef struct packed {
        logic [5:0]  tag;
        logic [23:0] imm;
        logic [2:0]  code;
    } sb_t;

    typedef struct {
        logic        en;
        logic [2:0]  code;
        logic [23:0] imm;
        logic [3:0]  rdy;
        logic        acc;
        logic [3:0]  fv;
        logic [2:0]  cnt;
        logic        stall;
        logic        ovf;
        logic [23:0] eimm;
        logic [5:0]  seq;
    } vec_t;

    sb_t        sb[$];
    sb_t        head_exp;
    vec_t       tbl[12];
    int         total = 0, bad = 0;
    logic [5:0] next_tag = '0;
    logic [3:0] one = 4'b0001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remaining payload fields are a fixed scramble of imm so field mix-ups are visible.
    function automatic logic [34:0] side(input logic [23:0] i);
        return {i[9:0], i[14:10] ^ 5'h1f, i[19:15], i[5:0], i[23:21], i[1:0], i[2:0], i[0]};
    endfunction

    task automatic set_instr(input logic [2:0] c, input logic [23:0] i);
        code   = c;
        imm    = i;
        addr   = {i, i[15:0], i};
        opcode = i[5:0];
        r1     = i[4:0];
        r3     = i[14:10];
        {xop, fmt, r2, u1, u2, u3, e1, e2, e3, r2z, r3i, imme, b1, b2, xope} = side(i);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [2:0] c, input logic [23:0] i);
        set_instr(c, i);
        enable = 1'b1;
        if (c < 3'd4) sb.push_back('{next_tag, i, c});
        next_tag = next_tag + 6'd1;
        step();
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    always @(negedge clock) begin
        if (resetn && |(d_fv & ready)) begin
            if (sb.size() == 0) chk("sb_unexpected_dispatch", {60'd0, d_fv}, 64'd0);
            else begin
                head_exp = sb.pop_front();
                chk("sb_tag", {58'd0, d_seq}, {58'd0, head_exp.tag});
                chk("sb_imm", {40'd0, d_imm}, {40'd0, head_exp.imm});
                chk("sb_fu_valid", {60'd0, d_fv}, {60'd0, one << head_exp.code});
                chk("sb_addr", d_addr, {head_exp.imm, head_exp.imm[15:0], head_exp.imm});
                chk("sb_fields", {47'd0, d_opcode, d_r1, d_r3}, {47'd0, head_exp.imm[5:0], head_exp.imm[4:0], head_exp.imm[14:10]});
                chk("sb_side", {29'd0, d_xop, d_fmt, d_r2, d_u1, d_u2, d_u3, d_e1, d_e2, d_e3, d_r2z, d_r3i, d_imme, d_b1, d_b2, d_xope},
                    {29'd0, side(head_exp.imm)});
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] exp_dcnt;
        enable = 1'b0;
        ready  = '0;
        set_instr(3'd0, 24'd0);
        tbl[0]  = '{1'b1, 3'd2, 24'h000123, 4'b0100, 1'b1, 4'b0100, 3'd1, 1'b0, 1'b0, 24'h000123, 6'd0};
        tbl[1]  = '{1'b0, 3'd0, 24'h000000, 4'b0100, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 24'h000000, 6'd0};
        tbl[2]  = '{1'b1, 3'd0, 24'h0000A0, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b0, 1'b0, 24'h0000A0, 6'd1};
        tbl[3]  = '{1'b1, 3'd0, 24'h0000A1, 4'b0000, 1'b1, 4'b0001, 3'd2, 1'b0, 1'b0, 24'h0000A0, 6'd1};
        tbl[4]  = '{1'b1, 3'd0, 24'h0000A2, 4'b0000, 1'b1, 4'b0001, 3'd3, 1'b1, 1'b0, 24'h0000A0, 6'd1};
        tbl[5]  = '{1'b1, 3'd0, 24'h0000A3, 4'b0000, 1'b1, 4'b0001, 3'd4, 1'b1, 1'b0, 24'h0000A0, 6'd1};
        tbl[6]  = '{1'b1, 3'd0, 24'h0000A4, 4'b0000, 1'b0, 4'b0001, 3'd4, 1'b1, 1'b1, 24'h0000A0, 6'd1};
        tbl[7]  = '{1'b0, 3'd0, 24'h000000, 4'b0001, 1'b0, 4'b0001, 3'd3, 1'b1, 1'b1, 24'h0000A1, 6'd2};
        tbl[8]  = '{1'b1, 3'd0, 24'h0000B0, 4'b0001, 1'b1, 4'b0001, 3'd3, 1'b1, 1'b1, 24'h0000A2, 6'd3};
        tbl[9]  = '{1'b0, 3'd0, 24'h000000, 4'b0001, 1'b0, 4'b0001, 3'd2, 1'b0, 1'b1, 24'h0000A3, 6'd4};
        tbl[10] = '{1'b0, 3'd0, 24'h000000, 4'b0001, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b1, 24'h0000B0, 6'd5};
        tbl[11] = '{1'b0, 3'd0, 24'h000000, 4'b0001, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1, 24'h000000, 6'd0};

        step();
        step();
        chk("reset_fu_valid", {60'd0, d_fv}, 64'd0);
        chk("reset_count", {61'd0, d_count}, 64'd0);
        chk("reset_stall_ovf_bad", {61'd0, d_stall, d_ovf, d_bad}, 64'd0);
        chk("reset_payload", {d_imm, d_addr[39:0]}, 64'd0);
        resetn = 1'b1;
        step();

        for (int n = 0; n < 12; n++) begin
            set_instr(tbl[n].code, tbl[n].imm);
            enable = tbl[n].en;
            ready  = tbl[n].rdy;
            if (tbl[n].en && tbl[n].acc) begin
                sb.push_back('{next_tag, tbl[n].imm, tbl[n].code});
                next_tag = next_tag + 6'd1;
            end
            step();
            chk($sformatf("vec%0d_fu_valid", n), {60'd0, d_fv}, {60'd0, tbl[n].fv});
            chk($sformatf("vec%0d_count", n), {61'd0, d_count}, {61'd0, tbl[n].cnt});
            chk($sformatf("vec%0d_stall", n), {63'd0, d_stall}, {63'd0, tbl[n].stall});
            chk($sformatf("vec%0d_overflow", n), {63'd0, d_ovf}, {63'd0, tbl[n].ovf});
            chk($sformatf("vec%0d_imm", n), {40'd0, d_imm}, {40'd0, tbl[n].eimm});
            chk($sformatf("vec%0d_tag", n), {58'd0, d_seq}, {58'd0, tbl[n].seq});
        end

        // Head-of-line blocking: unit 1 not ready holds the younger unit-0 entry.
        ready = 4'b0001;
        push_one(3'd1, 24'h0000C1);
        push_one(3'd0, 24'h0000C0);
        idle(3);
        chk("hol_fu_valid", {60'd0, d_fv}, 64'h2);
        chk("hol_count", {61'd0, d_count}, 64'd2);
        ready = 4'b0011;
        idle(3);
        chk("hol_drained", {61'd0, d_count}, 64'd0);

        // Invalid unit code is discarded with a one-cycle badFu pulse.
        ready = 4'b0000;
        push_one(3'd6, 24'h0000D6);
        enable = 1'b0;
        chk("bad_fu_valid", {60'd0, d_fv}, 64'd0);
        chk("bad_count_held", {61'd0, d_count}, 64'd1);
        chk("bad_pulse_before", {63'd0, d_bad}, 64'd0);
        step();
        chk("bad_count_discarded", {61'd0, d_count}, 64'd0);
        chk("bad_pulse_high", {63'd0, d_bad}, 64'd1);
        step();
        chk("bad_pulse_low", {63'd0, d_bad}, 64'd0);
        ready = 4'b1000;
        push_one(3'd3, 24'h0000E3);
        chk("bad_next_tag", {58'd0, d_seq}, {58'd0, next_tag - 6'd1});
        idle(2);

        // Reset with entries queued.
        ready = 4'b0000;
        push_one(3'd0, 24'h0000F1);
        push_one(3'd1, 24'h0000F2);
        push_one(3'd2, 24'h0000F3);
        chk("rst_pre_count", {61'd0, d_count}, 64'd3);
        #1 resetn = 1'b0;
        enable = 1'b0;
        #1;
        chk("rst_fu_valid", {60'd0, d_fv}, 64'd0);
        chk("rst_count", {61'd0, d_count}, 64'd0);
        chk("rst_ovf", {63'd0, d_ovf}, 64'd0);
        sb.delete();
        next_tag = '0;
        step();
        step();
        resetn = 1'b1;
        ready  = 4'b0001;
        push_one(3'd0, 24'h0000F0);
        enable = 1'b0;
        chk("rst_first_tag", {58'd0, d_seq}, 64'd0);
        idle(2);

        // Sequence wrap over 65 instructions with every unit ready.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        sb.delete();
        next_tag = '0;
        ready = 4'b1111;
        for (int n = 0; n < 65; n++) push_one(3'(n % 4), 24'h000100 + 24'(n));
        idle(3);
        chk("wrap_count", {61'd0, d_count}, 64'd0);
`ifdef DISPATCH_PERF_EN
        exp_dcnt = 32'd65;
`else
        exp_dcnt = 32'd0;
        chk("perf_stall_off", {32'd0, d_scnt}, 64'd0);
`endif
        chk("wrap_dispatch_count", {32'd0, d_dcnt}, {32'd0, exp_dcnt});

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_dispatch.md
# instruction_dispatch

Receiving end of the decode-stage-2 single instruction bus. Captures each muxed decoded instruction into an in-order FIFO, tags it with a sequence number and hands it to exactly one functional unit, selected by `functionalUnitCode`, using a per-unit valid/ready handshake. Upstream backpressure is provided through `stall_o`.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: number of instruction entries. Must be a power of two, ≥ 2.
- `NUM_FU`, default 4: number of functional-unit ports. Valid codes are `0..NUM_FU-1`; maximum 8.
- `SEQ_WIDTH`, default 6: width of the sequence tag.
- `immWidth`, default 24; `regWidth`, default 5; `opcodeWidth`, default 6; `XxoOpcodeWidth`, default 10; `formatIndexRange`, default 5: field widths.

Ports (clock and reset first, then inputs, then outputs):
- `clock_i` in 1: single clock, rising edge.
- `resetn_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: an instruction is present on the input bus this cycle.
- `instructionAddress_i` in 64; `opcode_i` in 6; `xOpcode_i` in 10; `xOpcodeEnable_i` in 1; `instructionFormat_i` in 5.
- `functionalUnitCode_i` in 3: selects the target unit.
- `reg1_i`/`reg2_i`/`reg3_i` in 5 each; `reg1Use_i`/`reg2Use_i`/`reg3Use_i` in 2 each; `reg1Enable_i`/`reg2Enable_i`/`reg3Enable_i` in 1 each.
- `reg2ValOrZero_i` in 1; `reg3IsImmediate_i` in 1.
- `imm_i` in 24; `immEnable_i` in 1; `bit1_i`, `bit2_i` in 1 each.
- `fuReady_i` in `NUM_FU`: unit k can accept an instruction.
- `stall_o` out 1: upstream must hold off sending new instructions.
- `fuValid_o` out `NUM_FU`: one-hot, FIFO head offered to unit k.
- Payload outputs: every input field above except `enable_i` has a matching output with the `_o` suffix and the same width, driven from the FIFO head.
- `seqTag_o` out `SEQ_WIDTH`: sequence tag of the head entry.
- `count_o` out `clog2(FIFO_DEPTH)+1`: current occupancy.
- `badFu_o` out 1: one-cycle pulse when an entry with an invalid unit code is discarded.
- `overflow_o` out 1: sticky flag, set when an instruction arrives while the FIFO is full.
- `dispatchCount_o` out 32; `stallCycles_o` out 32: performance counters (see Configuration).

## Operation

- **Push.** On a rising edge with `enable_i`=1 and count < `FIFO_DEPTH`, the input fields and the current sequence counter are written at the write pointer. The write pointer and the sequence counter then increment. The sequence counter wraps modulo 2^`SEQ_WIDTH`.
- **Full.** If `enable_i`=1 and count == `FIFO_DEPTH`, the instruction is dropped and `overflow_o` is set. `overflow_o` is cleared only by reset. Fullness uses the registered count, so a pop in the same cycle does not admit the push.
- **stall_o.** Asserted when count ≥ `FIFO_DEPTH`-1. This leaves one slot for an instruction already in flight in the upstream register.
- **Head offer.** If the FIFO is non-empty and the head's unit code c < `NUM_FU`, then `fuValid_o[c]`=1 and all other bits are 0. If the FIFO is empty, `fuValid_o`=0 and all payload outputs and `seqTag_o` are 0.
- **Pop.** The head is removed on the edge where `fuValid_o[c]` & `fuReady_i[c]`. Dispatch is strictly in order: a non-ready unit blocks all younger entries, and no reordering is allowed.
- **Invalid code.** If the head's code is ≥ `NUM_FU`, `fuValid_o` stays 0. The entry is popped on the next edge and `badFu_o` is driven to 1 for the following cycle.
- **Simultaneous push and pop when not full.** Both take effect and count is unchanged.

## Timing

- Latency from `enable_i` on edge N to `fuValid_o` is one cycle (visible after edge N) when the FIFO was empty.
- Throughput is one instruction per cycle in and out when the target unit is always ready.
- `fuValid_o`, the payload outputs, `seqTag_o`, `stall_o` and `count_o` are combinational from registered state only. They never depend combinationally on `enable_i` or `fuReady_i`.
- Reset (asynchronous assert, synchronous release):
  - Pointers, count and sequence counter go to 0.
  - `overflow_o`, `badFu_o` and the performance counters go to 0.
  - Consequently `fuValid_o`=0, `stall_o`=0 and all payloads are 0.
  - FIFO storage is not reset.
  - Any instruction in flight when reset asserts is lost. The first push after reset carries `seqTag_o`=0.

## Configuration

- `DISPATCH_PERF_EN` defined:
  - `dispatchCount_o` increments on every successful pop to a unit. `badFu_o` discards are not counted.
  - `stallCycles_o` increments every cycle in which `stall_o`=1.
  - Both are 32-bit counters that wrap.
- `DISPATCH_PERF_EN` undefined: the counter registers are not built, and both outputs are constant 0.

## Test plan

- **Single instruction.** Reset, then push one instruction with code 2 and `imm_i`=24'h000123, with `fuReady_i`=4'b0100. Required: next cycle `fuValid_o`=4'b0100, `imm_o`=24'h000123, `seqTag_o`=0; the following cycle count=0.
- **Fill and overflow.** Push 5 consecutive instructions with `fuReady_i`=0 and `FIFO_DEPTH`=4. Required: `stall_o` rises when count=3; count stops at 4; the 5th push is dropped and `overflow_o`=1.
- **Head-of-line blocking.** Push code 1 then code 0, with `fuReady_i`=4'b0001. Required: `fuValid_o`=4'b0010 and held, with no dispatch to unit 0. Raising `fuReady_i[1]` pops the entries in order with tags 0 and 1.
- **Invalid unit code.** Push code 6 with `NUM_FU`=4. Required: `fuValid_o`=0, the entry is discarded after one cycle, `badFu_o` pulses for exactly 1 cycle, and the next entry's tag is unaffected.
- **Sequence wrap.** With `SEQ_WIDTH`=6, pass 65 instructions with every unit ready. Required: tag sequence 0..63, then 0. With `DISPATCH_PERF_EN` defined, `dispatchCount_o`=65.
- **Reset mid-stream.** Assert `resetn_i` low with 3 entries queued. Required: `fuValid_o`=0 and count=0 immediately. After release, the next push gets tag 0.
